// File: rtl/div_arbiter.sv
// Two-requester round-robin front end for a 4-bit combinational divider.
// Divide-by-zero requests bypass the divider and return a substituted result.
module div_arbiter #(
  parameter int WIDTH         = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_dividend,
  input  logic [WIDTH-1:0] req0_divisor,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_dividend,
  input  logic [WIDTH-1:0] req1_divisor,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_quotient,
  output logic [WIDTH-1:0] rsp_remainder,
  output logic             rsp_div_zero,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_rr_last;
  logic [2:0]       r_cnt;
  logic [WIDTH-1:0] r_op_dividend;
  logic [WIDTH-1:0] r_op_divisor;
  logic             r_id;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem;
  logic             r_dz;

  logic             w_win;
  logic             w_accept;
  logic [WIDTH-1:0] w_sel_dd;
  logic [WIDTH-1:0] w_sel_dv;
  logic             w_zero;
  logic [WIDTH-1:0] w_div_q;
  logic [WIDTH-1:0] w_div_r;
  logic [WIDTH:0]   w_part;

  // Arbitration: a lone requester wins; on contention the one not served last wins.
  always_comb begin
    w_win      = (req0_valid && req1_valid) ? ~r_rr_last : req1_valid;
    w_accept   = (r_state == IDLE) && (req0_valid || req1_valid);
    req0_ready = w_accept && !w_win;
    req1_ready = w_accept && w_win;
    w_sel_dd   = w_win ? req1_dividend : req0_dividend;
    w_sel_dv   = w_win ? req1_divisor  : req0_divisor;
    w_zero     = (w_sel_dv == '0);
  end

  // Restoring divider on the operand registers; a 0 divisor never reaches it once loaded.
  always_comb begin
    w_div_q = '0;
    w_part  = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      w_part = {w_part[WIDTH-1:0], r_op_dividend[WIDTH-1-i]};
      if (w_part >= {1'b0, r_op_divisor}) begin
        w_part                = w_part - {1'b0, r_op_divisor};
        w_div_q[WIDTH-1-i]    = 1'b1;
      end
    end
    w_div_r = w_part[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    rsp_valid = 1'b0;
    busy      = 1'b1;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (w_accept) w_next = w_zero ? RESP : EXEC;
      end
      EXEC: begin
        if (r_cnt == 3'd1) w_next = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_last     <= 1'b1;
      r_cnt         <= '0;
      r_op_dividend <= '0;
      r_op_divisor  <= '0;
      r_id          <= 1'b0;
      r_quot        <= '0;
      r_rem         <= '0;
      r_dz          <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_rr_last <= w_win;
            r_id      <= w_win;
            if (w_zero) begin
              r_quot <= '1;
              r_rem  <= w_sel_dd;
              r_dz   <= 1'b1;
            end else begin
              r_op_dividend <= w_sel_dd;
              r_op_divisor  <= w_sel_dv;
              r_cnt         <= 3'(SETTLE_CYCLES);
            end
          end
        end
        EXEC: begin
          r_cnt <= r_cnt - 3'd1;
          if (r_cnt == 3'd1) begin
            r_quot <= w_div_q;
            r_rem  <= w_div_r;
            r_dz   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign rsp_id        = r_id;
  assign rsp_quotient  = r_quot;
  assign rsp_remainder = r_rem;
  assign rsp_div_zero  = r_dz;

endmodule

// File: tb/tb_div_arbiter.sv
// Bench for div_arbiter: two instances (settle 1 and 3) checked against
// integer divide arithmetic and a cycle-level handshake/latency model.
module tb_div_arbiter;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         r0v[2], r1v[2], rrdy[2], r0rdy[2], r1rdy[2], rv[2], rid[2], rdz[2], bsy[2];
  logic [W-1:0] r0dd[2], r0dv[2], r1dd[2], r1dv[2], rq[2], rr[2];

  int checks = 0;
  int failures = 0;
  bit rr_m[2];
  logic [W-1:0] last_dd[2], last_dv[2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    div_arbiter #(.WIDTH(W), .SETTLE_CYCLES(g == 0 ? 1 : 3)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(r0v[g]), .req0_ready(r0rdy[g]), .req0_dividend(r0dd[g]), .req0_divisor(r0dv[g]),
      .req1_valid(r1v[g]), .req1_ready(r1rdy[g]), .req1_dividend(r1dd[g]), .req1_divisor(r1dv[g]),
      .rsp_valid(rv[g]), .rsp_ready(rrdy[g]), .rsp_id(rid[g]), .rsp_quotient(rq[g]),
      .rsp_remainder(rr[g]), .rsp_div_zero(rdz[g]), .busy(bsy[g])
    );
  end

  function automatic int set_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic int lat_of(input int k, input logic [W-1:0] dv);
    return (dv == 0) ? 1 : set_of(k) + 1;
  endfunction

  function automatic logic [2*W+1:0] expect_rsp(input bit id, input logic [W-1:0] dd, input logic [W-1:0] dv);
    if (dv == 0) return {id, 4'hF, dd, 1'b1};
    return {id, 4'(dd / dv), 4'(dd % dv), 1'b0};
  endfunction

  task automatic drive(input int k, input bit id, input bit v, input logic [W-1:0] dd, input logic [W-1:0] dv);
    if (id) begin r1v[k] = v; r1dd[k] = dd; r1dv[k] = dv; end
    else    begin r0v[k] = v; r0dd[k] = dd; r0dv[k] = dv; end
  endtask

  task automatic apply_reset;
    for (int k = 0; k < 2; k++) begin
      drive(k, 0, 0, '0, '0); drive(k, 1, 0, '0, '0); rrdy[k] = 1'b0;
      rr_m[k] = 1'b1; last_dd[k] = '0; last_dv[k] = '0;
    end
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_reset;
    apply_reset;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({rv[k], bsy[k], rid[k], rq[k], rr[k], rdz[k], r0rdy[k], r1rdy[k]} !== '0) begin
        failures++;
        $display("FAIL reset_outputs k=%0d got=%h exp=0", k,
                 {rv[k], bsy[k], rid[k], rq[k], rr[k], rdz[k], r0rdy[k], r1rdy[k]});
      end
    end
    @(negedge clk);
  endtask

  // One isolated request with rsp_ready held high; starts and ends on a negedge.
  task automatic test_single(input int k, input bit id, input logic [W-1:0] dd, input logic [W-1:0] dv);
    int n;
    drive(k, id, 1, dd, dv); rrdy[k] = 1'b1;
    #1;
    checks++;
    if ({r1rdy[k], r0rdy[k]} !== (id ? 2'b10 : 2'b01)) begin
      failures++;
      $display("FAIL accept_ready k=%0d id=%0d got=%b exp=%b", k, id, {r1rdy[k], r0rdy[k]}, id ? 2'b10 : 2'b01);
    end
    @(negedge clk);
    drive(k, id, 0, dd, dv);
    rr_m[k] = id;
    if (dv != 0) begin last_dd[k] = dd; last_dv[k] = dv; end
    n = 1;
    while (rv[k] !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (n != lat_of(k, dv)) begin
      failures++;
      $display("FAIL latency k=%0d %0d/%0d got=%0d exp=%0d", k, dd, dv, n, lat_of(k, dv));
    end
    checks++;
    if ({rid[k], rq[k], rr[k], rdz[k]} !== expect_rsp(id, dd, dv)) begin
      failures++;
      $display("FAIL result k=%0d %0d/%0d got=%h exp=%h", k, dd, dv,
               {rid[k], rq[k], rr[k], rdz[k]}, expect_rsp(id, dd, dv));
    end
    @(negedge clk);
    checks++;
    if ({rv[k], bsy[k]} !== 2'b00) begin
      failures++;
      $display("FAIL idle_after k=%0d got=%b exp=00", k, {rv[k], bsy[k]});
    end
  endtask

  task automatic test_basic;
    test_single(0, 0, 4'd13, 4'd4);
  endtask

  // Both requesters held valid from reset: grants must alternate 0,1,0,1.
  task automatic test_round_robin;
    int n;
    bit w;
    logic [W-1:0] dd, dv;
    drive(0, 0, 1, 4'd9, 4'd3); drive(0, 1, 1, 4'd15, 4'd2); rrdy[0] = 1'b1;
    for (int t = 0; t < 4; t++) begin
      n = 0;
      #1;
      while (!(r0rdy[0] || r1rdy[0]) && n < 10) begin @(negedge clk); #1; n++; end
      w = (t % 2 == 1);
      checks++;
      if ({r1rdy[0], r0rdy[0]} !== (w ? 2'b10 : 2'b01)) begin
        failures++;
        $display("FAIL rr_grant t=%0d got=%b exp=%b", t, {r1rdy[0], r0rdy[0]}, w ? 2'b10 : 2'b01);
      end
      @(negedge clk);
      rr_m[0] = w;
      dd = w ? 4'd15 : 4'd9; dv = w ? 4'd2 : 4'd3;
      last_dd[0] = dd; last_dv[0] = dv;
      n = 1;
      while (rv[0] !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      checks++;
      if (n != 2) begin
        failures++;
        $display("FAIL rr_latency t=%0d got=%0d exp=2", t, n);
      end
      checks++;
      if ({rid[0], rq[0], rr[0], rdz[0]} !== expect_rsp(w, dd, dv)) begin
        failures++;
        $display("FAIL rr_result t=%0d got=%h exp=%h", t, {rid[0], rq[0], rr[0], rdz[0]}, expect_rsp(w, dd, dv));
      end
      @(negedge clk);
    end
    drive(0, 0, 0, '0, '0); drive(0, 1, 0, '0, '0);
  endtask

  task automatic test_div_zero;
    test_single(0, 1, 4'd11, 4'd0);
    checks++;
    if ({g_dut[0].u_dut.r_op_dividend, g_dut[0].u_dut.r_op_divisor} !== {last_dd[0], last_dv[0]}) begin
      failures++;
      $display("FAIL divzero_operands got=%h exp=%h",
               {g_dut[0].u_dut.r_op_dividend, g_dut[0].u_dut.r_op_divisor}, {last_dd[0], last_dv[0]});
    end
  endtask

  task automatic test_backpressure;
    int n;
    rrdy[0] = 1'b0;
    drive(0, 0, 1, 4'd7, 4'd7);
    @(negedge clk);
    drive(0, 0, 0, '0, '0); rr_m[0] = 1'b0;
    n = 1;
    while (rv[0] !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (n != 2) begin
      failures++;
      $display("FAIL bp_latency got=%0d exp=2", n);
    end
    drive(0, 1, 1, 4'd3, 4'd1);
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if ({rv[0], rid[0], rq[0], rr[0], rdz[0], r0rdy[0], r1rdy[0]} !== {1'b1, 1'b0, 4'd1, 4'd0, 1'b0, 2'b00}) begin
        failures++;
        $display("FAIL bp_hold c=%0d got=%h exp=%h", c,
                 {rv[0], rid[0], rq[0], rr[0], rdz[0], r0rdy[0], r1rdy[0]}, {1'b1, 1'b0, 4'd1, 4'd0, 1'b0, 2'b00});
      end
      @(negedge clk);
    end
    rrdy[0] = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if ({rv[0], bsy[0], r1rdy[0]} !== 3'b001) begin
      failures++;
      $display("FAIL bp_release got=%b exp=001", {rv[0], bsy[0], r1rdy[0]});
    end
    @(negedge clk);
    drive(0, 1, 0, '0, '0); rr_m[0] = 1'b1; last_dd[0] = 4'd3; last_dv[0] = 4'd1;
    n = 1;
    while (rv[0] !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    checks++;
    if ({rid[0], rq[0], rr[0], rdz[0]} !== expect_rsp(1'b1, 4'd3, 4'd1)) begin
      failures++;
      $display("FAIL bp_second got=%h exp=%h", {rid[0], rq[0], rr[0], rdz[0]}, expect_rsp(1'b1, 4'd3, 4'd1));
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    rrdy[0] = 1'b1;
    drive(0, 0, 1, 4'd6, 4'd3);
    @(negedge clk);
    drive(0, 0, 0, '0, '0);
    #2;
    checks++;
    if (bsy[0] !== 1'b1) begin
      failures++;
      $display("FAIL mid_busy got=%b exp=1", bsy[0]);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({rv[0], bsy[0], rid[0], rq[0], rr[0], rdz[0], r0rdy[0], r1rdy[0]} !== '0) begin
      failures++;
      $display("FAIL mid_reset_outputs got=%h exp=0", {rv[0], bsy[0], rid[0], rq[0], rr[0], rdz[0], r0rdy[0], r1rdy[0]});
    end
    for (int k = 0; k < 2; k++) begin rr_m[k] = 1'b1; last_dd[k] = '0; last_dv[k] = '0; end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    test_single(0, 0, 4'd5, 4'd2);
  endtask

  task automatic test_exhaustive;
    for (int k = 0; k < 2; k++)
      for (int p = 0; p < 256; p++)
        test_single(k, p[0], p[7:4], p[3:0]);
  endtask

  // Random traffic; the model tracks only "in flight / cycles until result / result held".
  task automatic test_random(input int k, input int cycles);
    bit mb, mv, mid, mdz, win, acc0, acc1;
    int mw;
    logic [W-1:0] mq, mr, dd, dv;
    logic [1:0] e;
    mb = 0; mv = 0; mid = 0; mdz = 0; mw = 0; mq = '0; mr = '0;
    drive(k, 0, 0, '0, '0); drive(k, 1, 0, '0, '0); rrdy[k] = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      acc0 = 0; acc1 = 0;
      if (!mb) begin
        if (r0v[k] || r1v[k]) begin
          win = (r0v[k] && r1v[k]) ? !rr_m[k] : r1v[k];
          rr_m[k] = win; mid = win; mb = 1; acc0 = !win; acc1 = win;
          dd = win ? r1dd[k] : r0dd[k];
          dv = win ? r1dv[k] : r0dv[k];
          mdz = (dv == 0);
          mq = mdz ? 4'hF : 4'(dd / dv);
          mr = mdz ? dd : 4'(dd % dv);
          mw = mdz ? 0 : set_of(k);
          mv = (mw == 0);
        end
      end else if (mv) begin
        if (rrdy[k]) begin mb = 0; mv = 0; end
      end else begin
        mw--;
        mv = (mw == 0);
      end
      checks++;
      if ({bsy[k], rv[k]} !== {mb, mv}) begin
        failures++;
        $display("FAIL rand_state k=%0d c=%0d got=%b exp=%b", k, c, {bsy[k], rv[k]}, {mb, mv});
      end
      if (mv) begin
        checks++;
        if ({rid[k], rq[k], rr[k], rdz[k]} !== {mid, mq, mr, mdz}) begin
          failures++;
          $display("FAIL rand_result k=%0d c=%0d got=%h exp=%h", k, c, {rid[k], rq[k], rr[k], rdz[k]}, {mid, mq, mr, mdz});
        end
      end
      if (r0v[k] && !acc0) begin
        if ($urandom_range(99) < 15) r0v[k] = 1'b0;
      end else if ($urandom_range(99) < 40)
        drive(k, 0, 1, 4'($urandom), ($urandom_range(4) == 0) ? 4'd0 : 4'($urandom));
      else r0v[k] = 1'b0;
      if (r1v[k] && !acc1) begin
        if ($urandom_range(99) < 15) r1v[k] = 1'b0;
      end else if ($urandom_range(99) < 40)
        drive(k, 1, 1, 4'($urandom), ($urandom_range(4) == 0) ? 4'd0 : 4'($urandom));
      else r1v[k] = 1'b0;
      rrdy[k] = ($urandom_range(99) < 60);
      #1;
      e = 2'b00;
      if (!mb) begin
        if (r0v[k] && r1v[k]) e = rr_m[k] ? 2'b01 : 2'b10;
        else                  e = {r1v[k], r0v[k]};
      end
      checks++;
      if ({r1rdy[k], r0rdy[k]} !== e) begin
        failures++;
        $display("FAIL rand_ready k=%0d c=%0d got=%b exp=%b", k, c, {r1rdy[k], r0rdy[k]}, e);
      end
    end
    drive(k, 0, 0, '0, '0); drive(k, 1, 0, '0, '0); rrdy[k] = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset;
    test_round_robin;
    test_basic;
    test_div_zero;
    test_backpressure;
    test_reset_mid;
    test_exhaustive;
    apply_reset;
    test_random(0, 1500);
    test_random(1, 1500);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
